// File: rtl/plic_claim_agent_pkg.sv
// Shared PLIC definitions: register offsets, ID width and claim-agent state encoding.
package plic_claim_agent_pkg;

    localparam logic [31:0] PLIC_CLAIMCOMP_ADDR = 32'h24;
    localparam int unsigned PLIC_IRQ_WIDTH      = 5;

    typedef enum logic [2:0] {
        StIdle,
        StClmSetup,
        StClmAccess,
        StDispatch,
        StWaitDone,
        StCmpSetup,
        StCmpAccess,
        StGap
    } plic_claim_state_e;

endpackage

// File: rtl/plic_claim_agent.sv
// PLIC target-side claim/complete engine: claims over APB, dispatches the ID to a
// hardware handler, and writes the completion back once the handler is done.
module plic_claim_agent
    import plic_claim_agent_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned IRQ_WIDTH      = PLIC_IRQ_WIDTH,
    parameter int unsigned SPUR_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      irq_i,
    output logic [31:0]               paddr_o,
    output logic [2:0]                pprot_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pstrb_o,
    input  logic                      pready_i,
    input  logic [31:0]               prdata_i,
    input  logic                      pslverr_i,
    output logic [IRQ_WIDTH-1:0]      id_o,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    input  logic                      done_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [SPUR_CNT_WIDTH-1:0] spur_cnt_o
);

    localparam logic [31:0] ClaimAddr = BASE_ADDR + PLIC_CLAIMCOMP_ADDR;

    plic_claim_state_e state_q;

    logic unused_prdata;
    assign unused_prdata = ^prdata_i[31:IRQ_WIDTH];

    assign pprot_o = 3'b000;
    assign busy_o  = (state_q != StIdle);

    // APB outputs are loaded on the transition into each phase so they are registered
    // and stay constant from SETUP through the pready cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            paddr_o    <= '0;
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            pwrite_o   <= 1'b0;
            pwdata_o   <= '0;
            pstrb_o    <= 4'h0;
            id_o       <= '0;
            id_valid_o <= 1'b0;
            err_o      <= 1'b0;
            spur_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (irq_i) begin
                        state_q   <= StClmSetup;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        paddr_o   <= ClaimAddr;
                        pstrb_o   <= 4'h0;
                    end
                end
                StClmSetup: begin
                    state_q   <= StClmAccess;
                    penable_o <= 1'b1;
                end
                StClmAccess: begin
                    if (pready_i) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        paddr_o   <= '0;
                        if (pslverr_i) begin
                            err_o   <= 1'b1;
                            state_q <= StGap;
                        end else if (prdata_i[IRQ_WIDTH-1:0] == '0) begin
                            if (spur_cnt_o != '1) begin
                                spur_cnt_o <= spur_cnt_o + SPUR_CNT_WIDTH'(1);
                            end
                            state_q <= StGap;
                        end else begin
                            id_o       <= prdata_i[IRQ_WIDTH-1:0];
                            id_valid_o <= 1'b1;
                            state_q    <= StDispatch;
                        end
                    end
                end
                StDispatch: begin
                    if (id_ready_i) begin
                        id_valid_o <= 1'b0;
                        state_q    <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (done_i) begin
                        state_q   <= StCmpSetup;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b1;
                        paddr_o   <= ClaimAddr;
                        pwdata_o  <= 32'(id_o);
                        pstrb_o   <= 4'hF;
                    end
                end
                StCmpSetup: begin
                    state_q   <= StCmpAccess;
                    penable_o <= 1'b1;
                end
                StCmpAccess: begin
                    if (pready_i) begin
                        err_o     <= pslverr_i;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        paddr_o   <= '0;
                        pwdata_o  <= '0;
                        pstrb_o   <= 4'h0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_claim_agent.sv
// Bench for plic_claim_agent: cycle-accurate APB/handler driver with expectations
// derived from the claim/complete protocol rules.
module tb_plic_claim_agent;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;
    logic [4:0]  id;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic        done = 1'b0;
    logic        busy, err;
    logic [7:0]  spur_cnt;

    int errors = 0;
    int checks = 0;
    int exp_spur = 0;

    always #5 clk = ~clk;

    plic_claim_agent dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .irq_i      (irq),
        .paddr_o    (paddr),
        .pprot_o    (pprot),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .pready_i   (pready),
        .prdata_i   (prdata),
        .pslverr_i  (pslverr),
        .id_o       (id),
        .id_valid_o (id_valid),
        .id_ready_i (id_ready),
        .done_i     (done),
        .busy_o     (busy),
        .err_o      (err),
        .spur_cnt_o (spur_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_psel"}, 32'(psel), 32'd0);
        chk({tag, "_penable"}, 32'(penable), 32'd0);
        chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
        chk({tag, "_paddr"}, paddr, 32'd0);
        chk({tag, "_pstrb"}, 32'(pstrb), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk_bus_idle(tag);
        chk({tag, "_pwdata"}, pwdata, 32'd0);
        chk({tag, "_pprot"}, 32'(pprot), 32'd0);
        chk({tag, "_id"}, 32'(id), 32'd0);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_spur"}, 32'(spur_cnt), 32'd0);
    endtask

    task automatic chk_apb(input string tag, input bit en, input bit wr, input logic [31:0] wd);
        chk({tag, "_psel"}, 32'(psel), 32'd1);
        chk({tag, "_penable"}, 32'(penable), 32'(en));
        chk({tag, "_pwrite"}, 32'(pwrite), 32'(wr));
        chk({tag, "_paddr"}, paddr, 32'h24);
        chk({tag, "_pstrb"}, 32'(pstrb), wr ? 32'hF : 32'h0);
        if (wr) chk({tag, "_pwdata"}, pwdata, wd);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // One full interrupt episode. Starts with the FSM idle (or already launched when armed)
    // and ends on the IDLE cycle, leaving irq at 'keep'.
    task automatic claim(input logic [31:0] rdata, input bit rerr, input int rwait,
                         input int rdy_wait, input int done_wait, input bit werr,
                         input int wwait, input bit armed, input bit keep,
                         input bit do_rst, input bit drop_irq);
        logic [4:0] exp_id;
        exp_id = rdata[4:0];
        if (!armed) begin
            @(negedge clk);
            irq = 1'b1;
        end
        @(negedge clk);
        chk_apb("clm_setup", 1'b0, 1'b0, 32'd0);
        chk("clm_setup_idv", 32'(id_valid), 32'd0);
        if (drop_irq) irq = 1'b0;
        for (int w = 0; w <= rwait; w++) begin
            @(negedge clk);
            chk_apb("clm_access", 1'b1, 1'b0, 32'd0);
            if (w == rwait) begin
                pready = 1'b1; prdata = rdata; pslverr = rerr;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            end
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0;
        if (rerr || exp_id == 5'd0) begin
            if (!rerr) exp_spur = (exp_spur == 255) ? 255 : exp_spur + 1;
            chk("clm_end_err", 32'(err), 32'(rerr));
            chk("clm_end_spur", 32'(spur_cnt), 32'(exp_spur));
            chk("clm_end_idv", 32'(id_valid), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            chk_bus_idle("clm_gap");
        end else begin
            chk("disp_idv", 32'(id_valid), 32'd1);
            chk("disp_id", 32'(id), 32'(exp_id));
            chk("disp_err", 32'(err), 32'd0);
            chk_bus_idle("disp");
            for (int r = 0; r < rdy_wait; r++) begin
                id_ready = 1'b0;
                done = 1'($urandom);
                @(negedge clk);
                chk("bp_idv", 32'(id_valid), 32'd1);
                chk("bp_id", 32'(id), 32'(exp_id));
                chk("bp_psel", 32'(psel), 32'd0);
            end
            id_ready = 1'b1;
            done = 1'($urandom);
            @(negedge clk);
            id_ready = 1'b0; done = 1'b0;
            chk("hs_idv", 32'(id_valid), 32'd0);
            chk("hs_psel", 32'(psel), 32'd0);
            chk("hs_busy", 32'(busy), 32'd1);
            for (int d = 0; d < done_wait; d++) begin
                @(negedge clk);
                chk("wait_psel", 32'(psel), 32'd0);
                chk("wait_idv", 32'(id_valid), 32'd0);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            chk_apb("cmp_setup", 1'b0, 1'b1, 32'(exp_id));
            for (int w = 0; w <= wwait; w++) begin
                @(negedge clk);
                chk_apb("cmp_access", 1'b1, 1'b1, 32'(exp_id));
                if (do_rst) begin
                    #2 rst = 1'b1;
                    #1 chk_reset("async_rst");
                    exp_spur = 0;
                    irq = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (w == wwait) begin
                    pready = 1'b1; pslverr = werr;
                end else begin
                    pready = 1'b0; pslverr = 1'($urandom);
                end
            end
            @(negedge clk);
            pready = 1'b0; pslverr = 1'b0;
            chk("cmp_gap_err", 32'(err), 32'(werr));
            chk("cmp_gap_busy", 32'(busy), 32'd1);
            chk_bus_idle("cmp_gap");
            chk("cmp_gap_pwdata", pwdata, 32'd0);
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_psel", 32'(psel), 32'd0);
        irq = keep;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_keep;
        bit keep;
        logic [31:0] rd;
        #2 rst = 1'b1;
        #1 chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic claim/complete.
        claim(32'h7, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);

        // Spurious claims, saturating counter; upper read bits must be ignored.
        claim(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            rd = $urandom;
            rd[4:0] = 5'd0;
            claim(rd, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("spur_saturated", 32'(spur_cnt), 32'd255);

        // Wait states and backpressure, irq dropped mid-claim.
        claim(32'hABCD_0013, 0, 3, 5, 2, 0, 3, 0, 0, 0, 1);

        // Slave error on the claim read, then on the completion write.
        claim(32'h9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        claim(32'h5, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0);

        // Back-to-back: irq stays high across the GAP/IDLE pair.
        claim(32'h3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        claim(32'hC, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);

        // Asynchronous reset during CMP_ACCESS, then a normal recovery episode.
        claim(32'h15, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0);
        claim(32'h1F, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);

        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) rd[4:0] = 5'd0;
            keep = (i < 39) ? 1'($urandom) : 1'b0;
            claim(rd, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom_range(0, 4), ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                  prev_keep, keep, 1'b0, 1'($urandom));
            prev_keep = keep;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
